// File: rtl/pc_next_select.sv
// IF-stage next-PC select: registered PC, fixed-priority redirect,
// stall hold, optional delay slot, misalign flag and redirect counter.
module pc_next_select #(
    parameter int               WIDTH        = 32,
    parameter int               STEP         = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               DELAY_SLOT   = 0,
    parameter int               CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] bta,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_addr,
    input  logic             jr,
    input  logic [WIDTH-1:0] jr_addr,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus_step,
    output logic             redirected,
    output logic             misalign,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic {IDLE, PENDING} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic             redirected_q, redirected_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             req;
    logic [WIDTH-1:0] sel_tgt;
    logic [WIDTH-1:0] aligned_tgt;

    assign pc_plus_step = pc_q + WIDTH'(STEP);
    assign req          = jr | jump | branch_taken;

    always_comb begin
        sel_tgt = bta;
        if (jr)
            sel_tgt = jr_addr;
        else if (jump)
            sel_tgt = jump_addr;
    end

    assign aligned_tgt = {sel_tgt[WIDTH-1:2], 2'b00};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        tgt_d        = tgt_q;
        redirected_d = 1'b0;
        misalign_d   = misalign_q;
        cnt_d        = cnt_q;
        if (!stall) begin
            if (state_q == PENDING) begin
                // delay-slot instruction issued; now jump to the held target
                pc_d         = tgt_q;
                redirected_d = 1'b1;
                state_d      = IDLE;
            end else if (req) begin
                misalign_d = misalign_q | (sel_tgt[1:0] != 2'b00);
                if (cnt_q != {CNT_W{1'b1}})
                    cnt_d = cnt_q + CNT_W'(1);
                if (DELAY_SLOT != 0) begin
                    pc_d    = pc_plus_step;
                    tgt_d   = aligned_tgt;
                    state_d = PENDING;
                end else begin
                    pc_d         = aligned_tgt;
                    redirected_d = 1'b1;
                end
            end else begin
                pc_d = pc_plus_step;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_VECTOR;
            tgt_q        <= '0;
            redirected_q <= 1'b0;
            misalign_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            tgt_q        <= tgt_d;
            redirected_q <= redirected_d;
            misalign_q   <= misalign_d;
            cnt_q        <= cnt_d;
        end
    end

    assign pc           = pc_q;
    assign redirected   = redirected_q;
    assign misalign     = misalign_q;
    assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_next_select.sv
// Directed bench for pc_next_select: one instance without delay slot
// (3-bit counter), one with delay slot.
module tb_pc_next_select;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] bta;
        logic        jump;
        logic [31:0] jaddr;
        logic        jr;
        logic [31:0] jraddr;
    } in_t;

    typedef struct {
        in_t         i;
        logic [31:0] pc;
        logic        red;
        logic        mis;
        logic [31:0] cnt;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    in_t a_in, b_in;
    int checks = 0;
    int failures = 0;

    logic [31:0] a_pc, a_pps, b_pc, b_pps;
    logic        a_red, a_mis, b_red, b_mis;
    logic [2:0]  a_cnt;
    logic [15:0] b_cnt;

    pc_next_select #(
        .WIDTH(32), .STEP(4), .RESET_VECTOR(32'h0040_0000),
        .DELAY_SLOT(0), .CNT_W(3)
    ) u_a (
        .clk(clk), .reset(a_in.rst), .stall(a_in.stall),
        .branch_taken(a_in.br), .bta(a_in.bta),
        .jump(a_in.jump), .jump_addr(a_in.jaddr),
        .jr(a_in.jr), .jr_addr(a_in.jraddr),
        .pc(a_pc), .pc_plus_step(a_pps), .redirected(a_red),
        .misalign(a_mis), .redirect_cnt(a_cnt)
    );

    pc_next_select #(
        .WIDTH(32), .STEP(4), .RESET_VECTOR(32'h0),
        .DELAY_SLOT(1), .CNT_W(16)
    ) u_b (
        .clk(clk), .reset(b_in.rst), .stall(b_in.stall),
        .branch_taken(b_in.br), .bta(b_in.bta),
        .jump(b_in.jump), .jump_addr(b_in.jaddr),
        .jr(b_in.jr), .jr_addr(b_in.jraddr),
        .pc(b_pc), .pc_plus_step(b_pps), .redirected(b_red),
        .misalign(b_mis), .redirect_cnt(b_cnt)
    );

    function automatic in_t mk(logic rst, logic stall,
                               logic br, logic [31:0] bta,
                               logic jump, logic [31:0] jaddr,
                               logic jr, logic [31:0] jraddr);
        in_t r;
        r.rst = rst; r.stall = stall;
        r.br = br; r.bta = bta;
        r.jump = jump; r.jaddr = jaddr;
        r.jr = jr; r.jraddr = jraddr;
        return r;
    endfunction

    function automatic vec_t mv(in_t i, logic [31:0] pc, logic red,
                                logic mis, logic [31:0] cnt);
        vec_t v;
        v.i = i; v.pc = pc; v.red = red; v.mis = mis; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step_a(vec_t v, int n);
        a_in = v.i;
        @(posedge clk);
        #1;
        chk($sformatf("a[%0d].pc", n), a_pc, v.pc);
        chk($sformatf("a[%0d].pps", n), a_pps, v.pc + 32'd4);
        chk($sformatf("a[%0d].red", n), {31'b0, a_red}, {31'b0, v.red});
        chk($sformatf("a[%0d].mis", n), {31'b0, a_mis}, {31'b0, v.mis});
        chk($sformatf("a[%0d].cnt", n), {29'b0, a_cnt}, v.cnt);
    endtask

    task automatic step_b(vec_t v, int n);
        b_in = v.i;
        @(posedge clk);
        #1;
        chk($sformatf("b[%0d].pc", n), b_pc, v.pc);
        chk($sformatf("b[%0d].pps", n), b_pps, v.pc + 32'd4);
        chk($sformatf("b[%0d].red", n), {31'b0, b_red}, {31'b0, v.red});
        chk($sformatf("b[%0d].mis", n), {31'b0, b_mis}, {31'b0, v.mis});
        chk($sformatf("b[%0d].cnt", n), {16'b0, b_cnt}, v.cnt);
    endtask

    vec_t ta[$];
    vec_t tb[$];

    initial begin
        in_t free, rst;
        free = mk(0, 0, 0, 0, 0, 0, 0, 0);
        rst  = mk(1, 0, 0, 0, 0, 0, 0, 0);
        a_in = rst;
        b_in = rst;

        // no delay slot: reset, sequential, priority, stall, misalign/wrap
        ta.push_back(mv(rst, 32'h0040_0000, 0, 0, 0));
        ta.push_back(mv(rst, 32'h0040_0000, 0, 0, 0));
        ta.push_back(mv(free, 32'h0040_0004, 0, 0, 0));
        ta.push_back(mv(free, 32'h0040_0008, 0, 0, 0));
        ta.push_back(mv(free, 32'h0040_000C, 0, 0, 0));
        ta.push_back(mv(mk(0, 0, 0, 0, 1, 32'h100, 0, 0), 32'h100, 1, 0, 1));
        ta.push_back(mv(mk(0, 0, 1, 32'h400, 1, 32'h300, 1, 32'h200),
                        32'h200, 1, 0, 2));
        ta.push_back(mv(free, 32'h204, 0, 0, 2));
        ta.push_back(mv(mk(0, 1, 1, 32'h80, 0, 0, 0, 0), 32'h204, 0, 0, 2));
        ta.push_back(mv(mk(0, 1, 1, 32'h80, 0, 0, 0, 0), 32'h204, 0, 0, 2));
        ta.push_back(mv(mk(0, 1, 1, 32'h80, 0, 0, 0, 0), 32'h204, 0, 0, 2));
        ta.push_back(mv(mk(0, 0, 1, 32'h80, 0, 0, 0, 0), 32'h80, 1, 0, 3));
        ta.push_back(mv(free, 32'h84, 0, 0, 3));
        ta.push_back(mv(mk(0, 0, 0, 0, 1, 32'hFFFF_FFFE, 0, 0),
                        32'hFFFF_FFFC, 1, 1, 4));
        ta.push_back(mv(free, 32'h0, 0, 1, 4));
        ta.push_back(mv(free, 32'h4, 0, 1, 4));
        ta.push_back(mv(mk(0, 0, 1, 32'h10, 0, 0, 0, 0), 32'h10, 1, 1, 5));
        ta.push_back(mv(mk(0, 0, 1, 32'h20, 0, 0, 0, 0), 32'h20, 1, 1, 6));
        ta.push_back(mv(mk(0, 0, 1, 32'h30, 0, 0, 0, 0), 32'h30, 1, 1, 7));
        ta.push_back(mv(mk(0, 0, 1, 32'h40, 0, 0, 0, 0), 32'h40, 1, 1, 7));
        ta.push_back(mv(rst, 32'h0040_0000, 0, 0, 0));

        // delay slot: jump, ignored jr, stall in pending, reset in pending
        tb.push_back(mv(rst, 32'h0, 0, 0, 0));
        tb.push_back(mv(free, 32'h4, 0, 0, 0));
        tb.push_back(mv(free, 32'h8, 0, 0, 0));
        tb.push_back(mv(free, 32'hC, 0, 0, 0));
        tb.push_back(mv(free, 32'h10, 0, 0, 0));
        tb.push_back(mv(mk(0, 0, 0, 0, 1, 32'h40, 0, 0), 32'h14, 0, 0, 1));
        tb.push_back(mv(mk(0, 0, 0, 0, 0, 0, 1, 32'h80), 32'h40, 1, 0, 1));
        tb.push_back(mv(free, 32'h44, 0, 0, 1));
        tb.push_back(mv(mk(0, 0, 0, 0, 1, 32'h100, 0, 0), 32'h48, 0, 0, 2));
        tb.push_back(mv(mk(0, 1, 0, 0, 0, 0, 0, 0), 32'h48, 0, 0, 2));
        tb.push_back(mv(free, 32'h100, 1, 0, 2));
        tb.push_back(mv(mk(0, 0, 0, 0, 1, 32'h200, 0, 0), 32'h104, 0, 0, 3));
        tb.push_back(mv(mk(1, 1, 0, 0, 0, 0, 0, 0), 32'h0, 0, 0, 0));
        tb.push_back(mv(free, 32'h4, 0, 0, 0));
        tb.push_back(mv(free, 32'h8, 0, 0, 0));
        tb.push_back(mv(mk(0, 0, 0, 0, 1, 32'h300, 0, 0), 32'hC, 0, 0, 1));
        tb.push_back(mv(mk(0, 0, 0, 0, 0, 0, 1, 32'h333), 32'h300, 1, 0, 1));
        tb.push_back(mv(free, 32'h304, 0, 0, 1));

        foreach (ta[k]) step_a(ta[k], k);
        foreach (tb[k]) step_b(tb[k], k);

        // 3-bit counter: 9 back-to-back branches, saturates at 7
        step_a(mv(rst, 32'h0040_0000, 0, 0, 0), 100);
        for (int k = 0; k < 9; k++) begin
            logic [31:0] t;
            t = 32'h1000 + 32'(k) * 32'h10;
            step_a(mv(mk(0, 0, 1, t, 0, 0, 0, 0), t, 1, 0,
                      (k < 7) ? 32'(k + 1) : 32'd7), 101 + k);
        end
        step_a(mv(free, 32'h1084, 0, 0, 7), 110);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
